// File: rtl/acl2_pkg.sv
// acl2_pkg: shared command encodings, FSM states and axis selector for the ACL2 sequencer
package acl2_pkg;
  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_X     = 4'b0001;
  localparam logic [3:0] OP_Y     = 4'b0010;
  localparam logic [3:0] OP_Z     = 4'b0100;
  localparam logic [3:0] OP_SETUP = 4'b1000;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_HOLD, S_CAPTURE, S_GAP, S_WAIT_PERIOD} state_t;
  typedef enum logic [1:0] {AX_X, AX_Y, AX_Z, AX_DONE} axis_t;
  function automatic logic [3:0] op_of(input state_t s, input axis_t a);
    return s == S_SETUP ? OP_SETUP : s != S_ISSUE ? OP_NONE :
           a == AX_X ? OP_X : a == AX_Y ? OP_Y : a == AX_Z ? OP_Z : OP_NONE;
  endfunction
endpackage

// File: rtl/acl2_cycle_counter.sv
// acl2_cycle_counter: up counter with clear, load and terminal-count flag
module acl2_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  input  logic [W-1:0] last,
  output logic         tc
);
  logic [W-1:0] count;
  assign tc = count == last;
  // clear wins over load, load wins over increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (load) count <= value;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/acl2_sample_sequencer.sv
// acl2_sample_sequencer: periodic X/Y/Z single-byte reads through an SPI controller
module acl2_sample_sequencer
  import acl2_pkg::*;
#(
  parameter int GAP_CYCLES     = 2443,
  parameter int PERIOD_CYCLES  = 1250000,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic       DONE_SETUP,
  input  logic       SPI_CS,
  input  logic [7:0] SPI_DATA,
  output logic [3:0] OPERATION,
  output logic [7:0] X_DATA,
  output logic [7:0] Y_DATA,
  output logic [7:0] Z_DATA,
  output logic       SAMPLE_VALID,
  output logic       BUSY,
  output logic       ERROR
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  axis_t axis, axis_n;
  logic stop, stop_n, cs_q, cap, err_set, p_clr, g_tc, p_tc, t_tc;
  logic [7:0] x_sh, y_sh;
  assign BUSY = state != S_IDLE;
  assign p_clr = state_n == S_ISSUE && state != S_ISSUE && axis_n == AX_X;
  acl2_cycle_counter #(.W(GW)) u_gap (
    .clk(CLK), .rst_n(RESET_N), .clear(state != S_GAP), .load(1'b0), .en(state == S_GAP),
    .value('0), .last(GW'(GAP_CYCLES - 1)), .tc(g_tc)
  );
  // saturates at the terminal count, so an overrun period stays flagged until cleared
  acl2_cycle_counter #(.W(PW)) u_period (
    .clk(CLK), .rst_n(RESET_N), .clear(p_clr), .load(1'b0), .en(!p_tc),
    .value('0), .last(PW'(PERIOD_CYCLES - 1)), .tc(p_tc)
  );
  acl2_cycle_counter #(.W(TW)) u_timeout (
    .clk(CLK), .rst_n(RESET_N), .clear(state != S_ISSUE), .load(1'b0), .en(state == S_ISSUE),
    .value('0), .last(TW'(TIMEOUT_CYCLES - 1)), .tc(t_tc)
  );
  // next-state, axis sequencing and per-cycle strobes
  always_comb begin
    state_n = state;
    axis_n = axis;
    stop_n = stop;
    cap = 1'b0;
    err_set = 1'b0;
    case (state)
      S_IDLE: begin
        axis_n = AX_X;
        stop_n = 1'b0;
        if (START) state_n = DONE_SETUP ? S_ISSUE : S_SETUP;
      end
      S_SETUP: if (DONE_SETUP) begin
        state_n = START ? S_GAP : S_IDLE;
        axis_n = AX_X;
      end
      S_ISSUE:
        if (!SPI_CS) state_n = S_HOLD;
        else if (!START) state_n = S_IDLE;
        else if (t_tc) begin
          state_n = S_GAP;
          err_set = 1'b1;
        end
      S_HOLD: begin
        if (!START) stop_n = 1'b1;
        if (SPI_CS && !cs_q) state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        cap = 1'b1;
        axis_n = axis_t'(axis + 2'd1);
        state_n = (stop || !START) ? S_IDLE : S_GAP;
      end
      S_GAP:
        if (!START) state_n = S_IDLE;
        else if (g_tc) state_n = axis == AX_DONE ? S_WAIT_PERIOD : S_ISSUE;
      S_WAIT_PERIOD:
        if (!START) state_n = S_IDLE;
        else if (p_tc) begin
          state_n = S_ISSUE;
          axis_n = AX_X;
        end
      default: state_n = S_IDLE;
    endcase
  end
  // control state and the registered command
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= S_IDLE;
      axis <= AX_X;
      stop <= 1'b0;
      cs_q <= 1'b1;
      OPERATION <= OP_NONE;
      ERROR <= 1'b0;
    end else begin
      state <= state_n;
      axis <= axis_n;
      stop <= stop_n;
      cs_q <= SPI_CS;
      OPERATION <= op_of(state_n, axis_n);
      ERROR <= ERROR | err_set;
    end
  // shadows collect X and Y; the Z capture publishes all three at once
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      x_sh <= '0;
      y_sh <= '0;
      X_DATA <= '0;
      Y_DATA <= '0;
      Z_DATA <= '0;
      SAMPLE_VALID <= 1'b0;
    end else begin
      x_sh <= state == S_IDLE ? '0 : cap && axis == AX_X ? SPI_DATA : x_sh;
      y_sh <= state == S_IDLE ? '0 : cap && axis == AX_Y ? SPI_DATA : y_sh;
      SAMPLE_VALID <= cap && axis == AX_Z;
      if (cap && axis == AX_Z) begin
        X_DATA <= x_sh;
        Y_DATA <= y_sh;
        Z_DATA <= SPI_DATA;
      end
    end
endmodule

// File: tb/tb_acl2_sample_sequencer.sv
// tb_acl2_sample_sequencer: directed checks of setup, sampling, period, timeout, stop and reset
module tb_acl2_sample_sequencer;
  logic CLK = 1'b0, RESET_N = 1'b0, START = 1'b0, DONE_SETUP = 1'b0, SPI_CS = 1'b1;
  logic [7:0] SPI_DATA = '0;
  logic [3:0] OPERATION;
  logic [7:0] X_DATA, Y_DATA, Z_DATA;
  logic SAMPLE_VALID, BUSY, ERROR;
  int checks = 0, errors = 0, cyc = 0, t_op = 0, t_x0 = 0, t_x1 = 0, t_x2 = 0;

  acl2_sample_sequencer #(.GAP_CYCLES(4), .PERIOD_CYCLES(100), .TIMEOUT_CYCLES(20)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .DONE_SETUP(DONE_SETUP), .SPI_CS(SPI_CS),
    .SPI_DATA(SPI_DATA), .OPERATION(OPERATION), .X_DATA(X_DATA), .Y_DATA(Y_DATA), .Z_DATA(Z_DATA),
    .SAMPLE_VALID(SAMPLE_VALID), .BUSY(BUSY), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic serve(input string tag, input logic [3:0] op, input logic [7:0] d, input int low_len);
    int n = 0;
    while (OPERATION !== op && n < 300) begin
      step();
      n++;
    end
    check({tag, "_op"}, OPERATION, op);
    t_op = cyc;
    SPI_DATA = d;
    SPI_CS = 1'b0;
    repeat (low_len) step();
    check({tag, "_hold_op"}, OPERATION, 4'b0000);
    SPI_CS = 1'b1;
  endtask

  initial begin
    repeat (2) step();
    check("rst_op", OPERATION, 4'b0000);
    check("rst_x", X_DATA, 8'h00);
    check("rst_y", Y_DATA, 8'h00);
    check("rst_z", Z_DATA, 8'h00);
    check("rst_valid", SAMPLE_VALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_error", ERROR, 1'b0);
    RESET_N = 1'b1;
    step();
    START = 1'b1;
    step();
    check("setup_op", OPERATION, 4'b1000);
    check("setup_busy", BUSY, 1'b1);
    repeat (3) step();
    check("setup_op_held", OPERATION, 4'b1000);
    DONE_SETUP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("setup_gap_op", OPERATION, 4'b0000);
    end
    step();
    check("first_issue_x", OPERATION, 4'b0001);
    serve("s1x", 4'b0001, 8'h12, 3);
    t_x0 = t_op;
    serve("s1y", 4'b0010, 8'h34, 3);
    serve("s1z", 4'b0100, 8'h56, 3);
    step();
    check("s1_valid_capture", SAMPLE_VALID, 1'b0);
    step();
    check("s1_valid", SAMPLE_VALID, 1'b1);
    check("s1_x", X_DATA, 8'h12);
    check("s1_y", Y_DATA, 8'h34);
    check("s1_z", Z_DATA, 8'h56);
    step();
    check("s1_valid_pulse_end", SAMPLE_VALID, 1'b0);
    serve("s2x", 4'b0001, 8'h9A, 3);
    t_x1 = t_op;
    check("period_s1_s2", t_x1 - t_x0, 100);
    serve("s2y", 4'b0010, 8'hBC, 3);
    serve("s2z", 4'b0100, 8'hDE, 3);
    repeat (2) step();
    check("s2_valid", SAMPLE_VALID, 1'b1);
    check("s2_z", Z_DATA, 8'hDE);
    serve("s3x", 4'b0001, 8'hA1, 40);
    t_x2 = t_op;
    check("period_s2_s3", t_x2 - t_x1, 100);
    serve("s3y", 4'b0010, 8'hB2, 40);
    serve("s3z", 4'b0100, 8'hC3, 40);
    repeat (2) step();
    check("s3_valid", SAMPLE_VALID, 1'b1);
    check("s3_x", X_DATA, 8'hA1);
    check("s3_y", Y_DATA, 8'hB2);
    check("s3_z", Z_DATA, 8'hC3);
    repeat (4) step();
    check("overrun_wait_op", OPERATION, 4'b0000);
    step();
    check("overrun_no_stall", OPERATION, 4'b0001);
    repeat (19) step();
    check("to_still_issue", OPERATION, 4'b0001);
    check("to_error_pre", ERROR, 1'b0);
    step();
    check("to_op_cleared", OPERATION, 4'b0000);
    check("to_error", ERROR, 1'b1);
    repeat (3) step();
    check("to_gap_op", OPERATION, 4'b0000);
    step();
    check("to_retry_x", OPERATION, 4'b0001);
    serve("s4x", 4'b0001, 8'h11, 2);
    for (int n = 0; n < 300 && OPERATION !== 4'b0010; n++) step();
    check("stop_y_op", OPERATION, 4'b0010);
    SPI_DATA = 8'h22;
    SPI_CS = 1'b0;
    step();
    START = 1'b0;
    step();
    check("stop_hold_busy", BUSY, 1'b1);
    SPI_CS = 1'b1;
    step();
    check("stop_capture_busy", BUSY, 1'b1);
    step();
    check("stop_idle_busy", BUSY, 1'b0);
    check("stop_no_valid", SAMPLE_VALID, 1'b0);
    check("stop_x_kept", X_DATA, 8'hA1);
    check("stop_y_kept", Y_DATA, 8'hB2);
    check("stop_z_kept", Z_DATA, 8'hC3);
    check("stop_error_sticky", ERROR, 1'b1);
    START = 1'b1;
    step();
    check("rs_issue_x", OPERATION, 4'b0001);
    SPI_CS = 1'b0;
    step();
    check("rs_hold_busy", BUSY, 1'b1);
    #2;
    RESET_N = 1'b0;
    START = 1'b0;
    SPI_CS = 1'b1;
    #1;
    check("rs_op", OPERATION, 4'b0000);
    check("rs_x", X_DATA, 8'h00);
    check("rs_y", Y_DATA, 8'h00);
    check("rs_z", Z_DATA, 8'h00);
    check("rs_valid", SAMPLE_VALID, 1'b0);
    check("rs_busy", BUSY, 1'b0);
    check("rs_error", ERROR, 1'b0);
    step();
    RESET_N = 1'b1;
    step();
    check("rs_idle_after", BUSY, 1'b0);
    START = 1'b1;
    step();
    check("restart_issue_x", OPERATION, 4'b0001);
    START = 1'b0;
    step();
    check("issue_stop_busy", BUSY, 1'b0);
    check("issue_stop_op", OPERATION, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acl2_sample_sequencer.md
ACL2_SAMPLE_SEQUENCER -- requirements
Module: acl2_sample_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2443, CS-high idle cycles between transactions.
REQ-002 SHALL have parameter PERIOD_CYCLES, default 1250000, CLK cycles from one sample start to the next (100 Hz at 125 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576, maximum wait for SPI_CS to fall after a read is requested.
REQ-004 SHALL have ports: CLK  in  1  system clock, 125 MHz.
REQ-005 RESET_N  in  1  asynchronous active-low reset.
REQ-006 START  in  1  level; 1 = run continuous sampling.
REQ-007 DONE_SETUP  in  1  setup-complete flag from SPI controller.
REQ-008 SPI_CS  in  1  SPI controller chip select, same clock domain.
REQ-009 SPI_DATA  in  8  SPI controller received byte.
REQ-010 OPERATION  out  4  one-hot command to SPI controller.
REQ-011 X_DATA, Y_DATA, Z_DATA  out  8 each  last complete sample.
REQ-012 SAMPLE_VALID  out  1  one-cycle pulse when X/Y/Z update.
REQ-013 BUSY  out  1  high in any state except IDLE.
REQ-014 ERROR  out  1  sticky timeout flag, cleared only by reset.

Function
REQ-015 States: IDLE, SETUP, ISSUE, HOLD, CAPTURE, GAP, WAIT_PERIOD.
REQ-016 IDLE: OPERATION=0000; START=1 and DONE_SETUP=0 -> SETUP; START=1 and DONE_SETUP=1 -> ISSUE with axis=X, period counter cleared.
REQ-017 SETUP: OPERATION=1000 until DONE_SETUP=1, then OPERATION=0000 and -> GAP with axis=X.
REQ-018 ISSUE: OPERATION = 0001/0010/0100 for axis X/Y/Z; on SPI_CS=0 -> HOLD next cycle.
REQ-019 HOLD: OPERATION=0000 (ends burst after one byte); on SPI_CS 0->1 edge (registered previous CS) -> CAPTURE.
REQ-020 CAPTURE: SPI_DATA written to shadow register of current axis; axis X->Y->Z; -> GAP.
REQ-021 After Z capture, X/Y/Z_DATA updated together from shadows and SAMPLE_VALID pulsed exactly one cycle, in the cycle after CAPTURE.
REQ-022 GAP: counts GAP_CYCLES with OPERATION=0000; then axis X/Y -> ISSUE; after Z -> WAIT_PERIOD.
REQ-023 WAIT_PERIOD: period counter (free-running from sample start, width ceil(log2(PERIOD_CYCLES+1))) reaches PERIOD_CYCLES-1 -> clear, ISSUE axis X; if already exceeded when entered, -> ISSUE next cycle.
REQ-024 Timeout: ISSUE lasting TIMEOUT_CYCLES with SPI_CS=1 -> ERROR<=1, OPERATION=0000, -> GAP, retry same axis.
REQ-025 START=0 observed in IDLE/GAP/WAIT_PERIOD/ISSUE-before-CS-fall -> IDLE next cycle, shadows discarded, outputs X/Y/Z unchanged.
REQ-026 START=0 in HOLD or CAPTURE -> current transaction completes (capture done), then IDLE; no SAMPLE_VALID unless Z completed.
REQ-027 START=0 in SETUP -> remain in SETUP until DONE_SETUP=1, then IDLE.
REQ-028 OPERATION SHALL be registered and never carry more than one bit set.

Reset
REQ-029 RESET_N=0 asynchronously forces IDLE, OPERATION=0000, X/Y/Z_DATA=00, shadows=00, SAMPLE_VALID=0, BUSY=0, ERROR=0, all counters 0, axis=X.
REQ-030 Reset mid-transaction SHALL not be recovered; next START restarts from IDLE rules.

Structure
REQ-031 Shared package acl2_pkg SHALL hold OPERATION encodings (X=0001, Y=0010, Z=0100, SETUP=1000, NONE=0000) and the state enumeration.
REQ-032 One sub-module, acl2_cycle_counter (load/clear/terminal-count, parameterised width), SHALL be instanced for gap, period and timeout counting.

Verification
REQ-033 DONE_SETUP=0, START=1 -> OPERATION=1000 until DONE_SETUP=1, then 0000 for GAP_CYCLES, then 0001.
REQ-034 Controller model returns X=12, Y=34, Z=56 -> single SAMPLE_VALID pulse, X_DATA=12, Y_DATA=34, Z_DATA=56, order X,Y,Z.
REQ-035 SPI_CS held high during ISSUE -> ERROR=1 after TIMEOUT_CYCLES, retry of same axis after GAP_CYCLES.
REQ-036 START=0 during HOLD of Y -> Y capture completes, IDLE, no SAMPLE_VALID, X/Y/Z_DATA unchanged.
REQ-037 PERIOD_CYCLES=100 with samples taking longer -> back-to-back samples, no WAIT_PERIOD stall.
REQ-038 RESET_N low for one cycle mid-HOLD -> all outputs at reset values immediately, IDLE.
